// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit controller: size and exception
// codes, FSM states, and the store-side lane helpers.
package lsu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam logic [1:0] EXC_NONE = 2'b00;
  localparam logic [1:0] EXC_ADEL = 2'b01;
  localparam logic [1:0] EXC_ADES = 2'b10;
  localparam logic [1:0] EXC_BUS  = 2'b11;

  typedef enum logic [1:0] {IDLE, BUS, RESP} state_e;

  // Reserved size 11 is treated as misaligned so it never reaches the bus.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      SZ_BYTE: misaligned = 1'b0;
      SZ_HALF: misaligned = lo[0];
      SZ_WORD: misaligned = (lo != 2'b00);
      default: misaligned = 1'b1;
    endcase
  endfunction

  function automatic logic [3:0] store_byteen(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      SZ_BYTE: store_byteen = 4'b0001 << lo;
      SZ_HALF: store_byteen = 4'b0011 << {lo[1], 1'b0};
      SZ_WORD: store_byteen = 4'b1111;
      default: store_byteen = 4'b0000;
    endcase
  endfunction

  function automatic logic [31:0] store_wdata(input logic [1:0] size, input logic [31:0] wdata);
    case (size)
      SZ_BYTE: store_wdata = {4{wdata[7:0]}};
      SZ_HALF: store_wdata = {2{wdata[15:0]}};
      default: store_wdata = wdata;
    endcase
  endfunction

endpackage

// File: rtl/load_ext.sv
// Load lane select and sign/zero extension of a bus read word.
module load_ext
  import lsu_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic [31:0] word,
  output logic [31:0] result
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    case (addr_lo)
      2'd0:    byte_lane = word[7:0];
      2'd1:    byte_lane = word[15:8];
      2'd2:    byte_lane = word[23:16];
      default: byte_lane = word[31:24];
    endcase
    half_lane = addr_lo[1] ? word[31:16] : word[15:0];

    case (size)
      SZ_BYTE: result = {{24{byte_lane[7] & ~is_unsigned}}, byte_lane};
      SZ_HALF: result = {{16{half_lane[15] & ~is_unsigned}}, half_lane};
      SZ_WORD: result = word;
      default: result = 32'h0;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store controller: one access at a time, alignment check, registered
// bus request with ack/timeout, and a one-cycle extended response.
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic [1:0]  resp_exc,
  output logic        stall,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_byteen,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  localparam logic [7:0] TO_LIMIT = 8'(TIMEOUT_CYCLES);

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [1:0]  size_q, size_d;
  logic [1:0]  lo_q, lo_d;
  logic        uns_q, uns_d;
  logic        bus_req_q, bus_req_d;
  logic        bus_we_q, bus_we_d;
  logic [31:0] bus_addr_q, bus_addr_d;
  logic [3:0]  bus_byteen_q, bus_byteen_d;
  logic [31:0] bus_wdata_q, bus_wdata_d;
  logic        resp_valid_q, resp_valid_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;
  logic [1:0]  resp_exc_q, resp_exc_d;
  logic [31:0] ext_data;

  load_ext u_load_ext (
    .addr_lo     (lo_q),
    .size        (size_q),
    .is_unsigned (uns_q),
    .word        (bus_rdata),
    .result      (ext_data)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    size_d       = size_q;
    lo_d         = lo_q;
    uns_d        = uns_q;
    bus_req_d    = bus_req_q;
    bus_we_d     = bus_we_q;
    bus_addr_d   = bus_addr_q;
    bus_byteen_d = bus_byteen_q;
    bus_wdata_d  = bus_wdata_q;
    resp_valid_d = 1'b0;
    resp_rdata_d = 32'h0;
    resp_exc_d   = EXC_NONE;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          size_d = req_size;
          lo_d   = req_addr[1:0];
          uns_d  = req_unsigned;
          if (misaligned(req_size, req_addr[1:0])) begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
            resp_exc_d   = req_we ? EXC_ADES : EXC_ADEL;
          end else begin
            state_d      = BUS;
            cnt_d        = 8'd0;
            bus_req_d    = 1'b1;
            bus_we_d     = req_we;
            bus_addr_d   = {req_addr[31:2], 2'b00};
            bus_byteen_d = req_we ? store_byteen(req_size, req_addr[1:0]) : 4'b0000;
            bus_wdata_d  = req_we ? store_wdata(req_size, req_wdata) : 32'h0;
          end
        end
      end
      BUS: begin
        // Ack is tested first so it wins over a coincident timeout.
        if (bus_ack || (cnt_q + 8'd1 == TO_LIMIT)) begin
          state_d      = RESP;
          resp_valid_d = 1'b1;
          resp_exc_d   = bus_ack ? EXC_NONE : EXC_BUS;
          resp_rdata_d = (bus_ack && !bus_we_q) ? ext_data : 32'h0;
          bus_req_d    = 1'b0;
          bus_we_d     = 1'b0;
          bus_addr_d   = 32'h0;
          bus_byteen_d = 4'b0000;
          bus_wdata_d  = 32'h0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= 8'd0;
      size_q       <= SZ_BYTE;
      lo_q         <= 2'b00;
      uns_q        <= 1'b0;
      bus_req_q    <= 1'b0;
      bus_we_q     <= 1'b0;
      bus_addr_q   <= 32'h0;
      bus_byteen_q <= 4'b0000;
      bus_wdata_q  <= 32'h0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'h0;
      resp_exc_q   <= EXC_NONE;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      size_q       <= size_d;
      lo_q         <= lo_d;
      uns_q        <= uns_d;
      bus_req_q    <= bus_req_d;
      bus_we_q     <= bus_we_d;
      bus_addr_q   <= bus_addr_d;
      bus_byteen_q <= bus_byteen_d;
      bus_wdata_q  <= bus_wdata_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_exc_q   <= resp_exc_d;
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign stall      = ((state_q == IDLE) && req_valid) || (state_q == BUS);
  assign bus_req    = bus_req_q;
  assign bus_we     = bus_we_q;
  assign bus_addr   = bus_addr_q;
  assign bus_byteen = bus_byteen_q;
  assign bus_wdata  = bus_wdata_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_exc   = resp_exc_q;

endmodule

// File: doc/lsu_ctrl.md
# lsu_ctrl

Load/store unit controller between the MEM pipeline stage and a variable-latency data-memory bus. It accepts one load or store at a time, checks alignment, and drives a word-aligned bus request with byte enables and lane-replicated write data. It holds a req/ack handshake with timeout, then returns a sign- or zero-extended load result with a one-cycle response pulse. It stalls the pipeline while an access is outstanding.

## Interface
Parameters:
- TIMEOUT_CYCLES, 64: BUS-state cycles without ack before the access is aborted with a bus error (range 1..255).

Ports (reset is asynchronous, active-low):
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  MEM stage presents an access
- req_ready  out  1  controller can accept (high only in IDLE)
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 halfword, 10 word, 11 reserved
- req_unsigned  in  1  zero-extend load (lbu/lhu)
- req_addr  in  32  byte address
- req_wdata  in  32  store data, in the low bits
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  extended load data; 0 for stores and errors
- resp_exc  out  2  00 none, 01 AdEL, 10 AdES, 11 bus timeout
- stall  out  1  freeze the pipeline
- bus_req  out  1  bus request, held until ack or timeout
- bus_we  out  1  bus write
- bus_addr  out  32  {req_addr[31:2], 2'b00}
- bus_byteen  out  4  byte lane enables
- bus_wdata  out  32  lane-replicated store data
- bus_ack  in  1  bus completion, one cycle
- bus_rdata  in  32  read word, valid with bus_ack

## Operation
- FSM states:
  - IDLE: accept when req_valid is high, latching all req_* fields. Aligned access → BUS. Misaligned access or size 11 → RESP with exc 01 (load) or 10 (store); no bus activity.
  - BUS: bus_req=1, with all bus_* outputs stable.
    - bus_ack → RESP, capturing bus_rdata.
    - Timeout counter reaches TIMEOUT_CYCLES → RESP with exc 11.
  - RESP: resp_valid=1 for exactly one cycle → IDLE.
- Alignment rules: halfword needs addr[0]=0; word needs addr[1:0]=00.
- Byte enables:
  - byte: 4'b0001 << addr[1:0]
  - half: 4'b0011 << {addr[1],1'b0}
  - word: 4'b1111
  - bus_byteen is 0 for loads; loads always read the whole word.
- Write data: byte replicated ×4, half ×2, word unchanged.
- Load extension:
  - Lane select by latched addr[1:0] (byte) or addr[1] (half).
  - Sign-extend unless req_unsigned is set; word ignores req_unsigned.
- Stall: stall = (state==IDLE & req_valid) | state==BUS. Stall is low in RESP, so the pipeline captures the response and advances.
- bus_ack outside BUS is ignored. When ack and timeout fall on the same cycle, ack wins.
- Timeout counter clears on every entry to BUS.

## Timing
- Reset values (asynchronous): state IDLE, counter 0. Outputs:
  - bus_req, bus_we, bus_addr, bus_byteen, bus_wdata = 0
  - resp_valid, resp_rdata, resp_exc = 0
  - req_ready=1; stall=0 while req_valid is low
- Latencies, with the accept edge at cycle k:
  - bus_req is high from cycle k+1.
  - With ack sampled at edge m, resp_valid is high in cycle m+1. Minimum load/store latency is 2 cycles after accept.
  - Misaligned access: resp_valid in cycle k+1.
  - Timeout: bus_req drops after exactly TIMEOUT_CYCLES cycles high; resp_valid follows in the next cycle.
- Back-to-back accesses: the next accept is possible in the cycle after RESP. Peak throughput is one access per 3 cycles.
- Reset mid-access: bus_req drops immediately and no response is issued. After reset deasserts, the bus must not deliver a stale ack.
- All bus_* outputs are registered. resp_* outputs are registered and held at 0 outside RESP.

## Structure
- Shared package lsu_pkg holds:
  - size codes (SZ_BYTE, SZ_HALF, SZ_WORD)
  - exception codes (EXC_NONE, EXC_ADEL, EXC_ADES, EXC_BUS)
  - the state enum (IDLE, BUS, RESP)
- One sub-module, load_ext: combinational lane select and extension (addr[1:0], size, unsigned, word → 32-bit result), instantiated on the RESP-capture path.

## Test plan
- Store byte, addr 0x1003, wdata 0x000000AB, ack after 3 BUS cycles → bus_addr 0x1000, byteen 1000, bus_wdata 0xABABABAB; resp_valid 1 cycle after ack with exc 00; stall high for 4 cycles.
- Load half signed at 0x2002, bus_rdata 0x8001_1234 → resp_rdata 0xFFFF8001. The same load with unsigned → 0x00008001.
- Load word at 0x3001 → resp_valid in cycle k+1 with exc 01; bus_req never asserts. Store half at 0x3001 → exc 10.
- TIMEOUT_CYCLES=4, no ack → bus_req high exactly 4 cycles; resp exc 11, rdata 0. A late ack in the following IDLE is ignored.
- Ack asserted in the cycle the counter hits the limit → exc 00 with the data captured.
- rst_n pulled low in the second BUS cycle → bus_req 0 immediately, no resp_valid. A fresh load after release completes normally.
